// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - Requester, response and memory-side signal bundle for mem_arbiter
//
// Purpose: groups every bus signal of the two-port burst arbiter. The arbiter
// connects through the slave modport. The requesters and the memory connect
// through the master modport.
// Ports (members):
//   i_req*/i_we*/i_addr*/i_wdata*  requester 0/1 burst request side
//   o_gnt*/o_rvalid*/o_done*       per-requester ownership and response
//   o_beat_cnt/o_rdata             shared beat index and registered read data
//   o_mem_*/i_mem_*                single-port memory side
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int BURST_LEN  = 4
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic                  i_req0;
    logic                  i_we0;
    logic [ADDR_WIDTH-1:0] i_addr0;
    logic [DATA_WIDTH-1:0] i_wdata0;
    logic                  i_req1;
    logic                  i_we1;
    logic [ADDR_WIDTH-1:0] i_addr1;
    logic [DATA_WIDTH-1:0] i_wdata1;

    logic                  o_gnt0;
    logic                  o_gnt1;
    logic [BEAT_W-1:0]     o_beat_cnt;
    logic                  o_rvalid0;
    logic                  o_rvalid1;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_done0;
    logic                  o_done1;

    logic                  o_mem_write_en;
    logic [DATA_WIDTH-1:0] o_mem_data;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] i_mem_read_data;
    logic                  i_mem_access;

    modport slave (
        input  i_req0, i_we0, i_addr0, i_wdata0,
        input  i_req1, i_we1, i_addr1, i_wdata1,
        output o_gnt0, o_gnt1, o_beat_cnt,
        output o_rvalid0, o_rvalid1, o_rdata, o_done0, o_done1,
        output o_mem_write_en, o_mem_data, o_mem_addr,
        input  i_mem_read_data, i_mem_access
    );

    modport master (
        output i_req0, i_we0, i_addr0, i_wdata0,
        output i_req1, i_we1, i_addr1, i_wdata1,
        input  o_gnt0, o_gnt1, o_beat_cnt,
        input  o_rvalid0, o_rvalid1, o_rdata, o_done0, o_done1,
        input  o_mem_write_en, o_mem_data, o_mem_addr,
        output i_mem_read_data, i_mem_access
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Two-port round-robin arbiter and burst sequencer for a single-port memory
//
// Purpose: grants one of two requesters a BURST_LEN-beat burst at consecutive
// word addresses. It sequences the beats on the memory's one-cycle access
// pulse and returns registered read data plus a completion pulse to the owner.
// Ports:
//   i_clk   clock
//   i_arst  synchronous active-high reset
//   bus     mem_arbiter_if.slave: requester, response and memory signals
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 64,
    parameter int BURST_LEN  = 4
) (
    input  logic          i_clk,
    input  logic          i_arst,
    mem_arbiter_if.slave  bus
);
    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  last_q, last_d;      // last-served requester id
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] hold_q, hold_d;      // memory address shown outside BUSY
    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;

    logic                  pick;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] beat_addr;

    // Linear word stepping; any carry out of ADDR_WIDTH simply falls off.
    assign beat_addr = addr_q + (ADDR_WIDTH'(beat_q) << 2);
    assign last_beat = (beat_q == LAST_BEAT);

    // On a tie, serve whichever requester did not go last.
    always_comb begin
        pick = 1'b0;
        if (bus.i_req0 && bus.i_req1) begin
            pick = ~last_q;
        end else if (bus.i_req1) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        rdata_d   = rdata_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req0 || bus.i_req1) begin
                    state_d     = ST_BUSY;
                    owner_d     = pick;
                    last_d      = pick;
                    we_d        = pick ? bus.i_we1 : bus.i_we0;
                    addr_d      = pick ? bus.i_addr1 : bus.i_addr0;
                    addr_d[1:0] = 2'b00;
                    beat_d      = '0;
                    gnt0_d      = ~pick;
                    gnt1_d      = pick;
                end
            end
            ST_BUSY: begin
                // Track the live address so it stays put after the burst ends.
                hold_d = beat_addr;
                if (bus.i_mem_access) begin
                    beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
                    if (!we_q) begin
                        rdata_d   = bus.i_mem_read_data;
                        rvalid0_d = ~owner_q;
                        rvalid1_d = owner_q;
                    end
                    if (last_beat) begin
                        state_d = ST_DONE;
                        done0_d = ~owner_q;
                        done1_d = owner_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            hold_q    <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata_q   <= rdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
        end
    end

    assign bus.o_gnt0     = gnt0_q;
    assign bus.o_gnt1     = gnt1_q;
    assign bus.o_beat_cnt = beat_q;
    assign bus.o_rvalid0  = rvalid0_q;
    assign bus.o_rvalid1  = rvalid1_q;
    assign bus.o_rdata    = rdata_q;
    assign bus.o_done0    = done0_q;
    assign bus.o_done1    = done1_q;

    assign bus.o_mem_addr = (state_q == ST_BUSY) ? beat_addr : hold_q;
    assign bus.o_mem_data = owner_q ? bus.i_wdata1 : bus.i_wdata0;
    // Reset gates the strobe directly so an aborted beat never writes.
    assign bus.o_mem_write_en = (state_q == ST_BUSY) & we_q & bus.i_mem_access & ~i_arst;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int DW        = 32;
    localparam int AW        = 64;
    localparam int BL        = 4;
    localparam int MEM_WORDS = 4096;

    logic clk;
    logic arst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
        .i_clk  (clk),
        .i_arst (arst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    int checks = 0;
    int errors = 0;

    beat_t       exp_beat0[$];
    beat_t       exp_beat1[$];
    logic [31:0] exp_rd0[$];
    logic [31:0] exp_rd1[$];
    int          exp_own[$];
    bit          ord_en = 1'b1;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] wbase0 = '0;
    logic [31:0] wbase1 = '0;
    bit          rnd_access = 1'b0;
    bit          man_mode   = 1'b0;
    bit          man_access = 1'b0;

    assign bus.i_wdata0        = wbase0 + DW'(bus.o_beat_cnt);
    assign bus.i_wdata1        = wbase1 + DW'(bus.o_beat_cnt);
    assign bus.i_mem_access    = man_mode ? man_access : rnd_access;
    assign bus.i_mem_read_data = mem[bus.o_mem_addr[13:2]];

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: a burst touches nbeats consecutive words from the aligned start.
    task automatic expect_burst(input int r, input bit we, input logic [63:0] a,
                                input logic [31:0] wb, input int nbeats);
        beat_t       b;
        logic [63:0] base;
        base = {a[63:2], 2'b00};
        for (int i = 0; i < nbeats; i++) begin
            b.addr  = base + 64'(4 * i);
            b.we    = we;
            b.wdata = wb + 32'(i);
            if (we) ref_mem[b.addr[13:2]] = b.wdata;
            if (r == 0) begin
                exp_beat0.push_back(b);
                if (!we) exp_rd0.push_back(ref_mem[b.addr[13:2]]);
            end else begin
                exp_beat1.push_back(b);
                if (!we) exp_rd1.push_back(ref_mem[b.addr[13:2]]);
            end
        end
    endtask

    task automatic drive_req(input int r, input bit req, input bit we,
                             input logic [63:0] a, input logic [31:0] wb);
        if (r == 0) begin
            bus.i_req0 = req; bus.i_we0 = we; bus.i_addr0 = a; wbase0 = wb;
        end else begin
            bus.i_req1 = req; bus.i_we1 = we; bus.i_addr1 = a; wbase1 = wb;
        end
    endtask

    // Issue n back-to-back bursts holding the request, then release it on the last done.
    task automatic run_burst(input int r, input bit we, input logic [63:0] a,
                             input logic [31:0] wb, input int n);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        for (int k = 0; k < n; k++) expect_burst(r, we, a, wb, BL);
        drive_req(r, 1'b1, we, a, wb);
        while (got < n && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((r == 0) ? bus.o_done0 : bus.o_done1) got++;
        end
        chk_eq($sformatf("done_count_r%0d", r), 64'(got), 64'(n));
        if (r == 0) bus.i_req0 = 1'b0;
        else bus.i_req1 = 1'b0;
    endtask

    // Memory: commit writes mid-cycle, randomize the access pulse after each edge.
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        for (int i = 0; i < 4; i++) mem[12'h400 + i] = 32'hA + 32'(i);
        forever begin
            @(negedge clk);
            if (bus.o_mem_write_en && bus.i_mem_access)
                mem[bus.o_mem_addr[13:2]] = bus.o_mem_data;
            @(posedge clk);
            #1;
            rnd_access = ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor
    logic pg0 = 1'b0;
    logic pg1 = 1'b0;
    int   beats0 = 0;
    int   beats1 = 0;
    bit   lastwe0 = 1'b0;
    bit   lastwe1 = 1'b0;

    task automatic mon_beat(input int r);
        beat_t b;
        int    sz;
        sz = (r == 0) ? exp_beat0.size() : exp_beat1.size();
        chk_eq($sformatf("beat_expected_r%0d", r), 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            b = (r == 0) ? exp_beat0.pop_front() : exp_beat1.pop_front();
            chk_eq($sformatf("beat_addr_r%0d", r), bus.o_mem_addr, b.addr);
            chk_eq($sformatf("beat_we_r%0d", r), 64'(bus.o_mem_write_en), 64'(b.we));
            if (b.we) chk_eq($sformatf("beat_wdata_r%0d", r), 64'(bus.o_mem_data), 64'(b.wdata));
            if (r == 0) begin lastwe0 = b.we; beats0++; end
            else begin lastwe1 = b.we; beats1++; end
        end
    endtask

    task automatic mon_rvalid(input int r);
        int          sz;
        logic [31:0] d;
        sz = (r == 0) ? exp_rd0.size() : exp_rd1.size();
        chk_eq($sformatf("rvalid_expected_r%0d", r), 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            d = (r == 0) ? exp_rd0.pop_front() : exp_rd1.pop_front();
            chk_eq($sformatf("rdata_r%0d", r), 64'(bus.o_rdata), 64'(d));
        end
    endtask

    task automatic mon_done(input int r);
        int n;
        bit lw;
        n  = (r == 0) ? beats0 : beats1;
        lw = (r == 0) ? lastwe0 : lastwe1;
        chk_eq($sformatf("beats_per_burst_r%0d", r), 64'(n), 64'(BL));
        chk_eq($sformatf("rvalid_with_done_r%0d", r),
               64'((r == 0) ? bus.o_rvalid0 : bus.o_rvalid1), 64'(!lw));
        if (r == 0) beats0 = 0;
        else beats1 = 0;
    endtask

    task automatic mon_grant(input int r);
        int e;
        if (ord_en) begin
            chk_eq($sformatf("grant_expected_r%0d", r), 64'(exp_own.size() > 0), 64'd1);
            if (exp_own.size() > 0) begin
                e = exp_own.pop_front();
                chk_eq("grant_owner", 64'(r), 64'(e));
            end
        end
    endtask

    always @(negedge clk) begin
        if (arst) begin
            chk_eq("we_during_reset", 64'(bus.o_mem_write_en), 64'd0);
            beats0 = 0;
            beats1 = 0;
        end else begin
            chk_eq("gnt_exclusive", 64'(bus.o_gnt0 & bus.o_gnt1), 64'd0);
            if ((bus.o_gnt0 && !bus.o_done0) && bus.i_mem_access) mon_beat(0);
            else if ((bus.o_gnt1 && !bus.o_done1) && bus.i_mem_access) mon_beat(1);
            else chk_eq("no_spurious_we", 64'(bus.o_mem_write_en), 64'd0);
            if (bus.o_gnt0 && !pg0) mon_grant(0);
            if (bus.o_gnt1 && !pg1) mon_grant(1);
            if (bus.o_rvalid0) mon_rvalid(0);
            if (bus.o_rvalid1) mon_rvalid(1);
            if (bus.o_done0) mon_done(0);
            if (bus.o_done1) mon_done(1);
        end
        pg0 = bus.o_gnt0;
        pg1 = bus.o_gnt1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0t expected < 500000", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int cyc;
        int bad;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i);
        for (int i = 0; i < 4; i++) ref_mem[12'h400 + i] = 32'hA + 32'(i);
        arst = 1'b1;
        drive_req(0, 1'b0, 1'b0, '0, '0);
        drive_req(1, 1'b0, 1'b0, '0, '0);
        wait_cycles(3);
        arst = 1'b0;

        @(negedge clk);
        chk_eq("rst_gnt0", 64'(bus.o_gnt0), 64'd0);
        chk_eq("rst_gnt1", 64'(bus.o_gnt1), 64'd0);
        chk_eq("rst_beat", 64'(bus.o_beat_cnt), 64'd0);
        chk_eq("rst_rvalid", 64'({bus.o_rvalid1, bus.o_rvalid0}), 64'd0);
        chk_eq("rst_done", 64'({bus.o_done1, bus.o_done0}), 64'd0);
        chk_eq("rst_rdata", 64'(bus.o_rdata), 64'd0);
        chk_eq("rst_mem_addr", bus.o_mem_addr, 64'd0);
        @(posedge clk);
        #1;

        // Single read from an unaligned start.
        exp_own.push_back(0);
        run_burst(0, 1'b0, 64'h1003, 32'h0, 1);
        wait_cycles(2);

        // Write burst from requester 1.
        exp_own.push_back(1);
        run_burst(1, 1'b1, 64'h2000, 32'h100, 1);
        wait_cycles(2);
        for (int i = 0; i < 4; i++)
            chk_eq($sformatf("wr_mem_%0d", i), 64'(mem[12'h800 + i]), 64'(32'h100 + 32'(i)));

        // Tie straight out of reset, twice.
        arst = 1'b1;
        wait_cycles(1);
        arst = 1'b0;
        exp_own.push_back(0);
        exp_own.push_back(1);
        fork
            run_burst(0, 1'b0, 64'h1000, 32'h0, 1);
            run_burst(1, 1'b0, 64'h2004, 32'h0, 1);
        join
        wait_cycles(2);
        exp_own.push_back(0);
        exp_own.push_back(1);
        fork
            run_burst(0, 1'b1, 64'h1800, 32'h300, 1);
            run_burst(1, 1'b0, 64'h2000, 32'h0, 1);
        join
        wait_cycles(2);

        // Requester 0 holds its request across done while requester 1 waits.
        exp_own.push_back(0);
        exp_own.push_back(1);
        exp_own.push_back(0);
        fork
            run_burst(0, 1'b0, 64'h1000, 32'h0, 2);
            begin
                wait_cycles(2);
                run_burst(1, 1'b0, 64'h2000, 32'h0, 1);
            end
        join
        wait_cycles(2);

        // Address carry off the top of the address space.
        exp_own.push_back(1);
        run_burst(1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, 32'h0, 1);
        wait_cycles(2);

        // Access pulses while idle.
        man_mode   = 1'b1;
        man_access = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_eq("idle_gnt", 64'({bus.o_gnt1, bus.o_gnt0}), 64'd0);
            chk_eq("idle_beat", 64'(bus.o_beat_cnt), 64'd0);
            chk_eq("idle_rvalid", 64'({bus.o_rvalid1, bus.o_rvalid0}), 64'd0);
            chk_eq("idle_we", 64'(bus.o_mem_write_en), 64'd0);
            @(posedge clk);
            #1;
        end
        man_access = 1'b0;

        // Reset during beat 2 of a write, coincident with the access pulse.
        exp_own.push_back(0);
        expect_burst(0, 1'b1, 64'h3000, 32'h200, 2);
        drive_req(0, 1'b1, 1'b1, 64'h3000, 32'h200);
        cyc = 0;
        while (!bus.o_gnt0 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk_eq("rw_grant", 64'(bus.o_gnt0), 64'd1);
        repeat (2) begin
            man_access = 1'b1;
            wait_cycles(1);
            man_access = 1'b0;
            wait_cycles(1);
        end
        chk_eq("rw_beat_before", 64'(bus.o_beat_cnt), 64'd2);
        man_access = 1'b1;
        arst       = 1'b1;
        bus.i_req0 = 1'b0;
        @(negedge clk);
        chk_eq("rw_we_on_reset", 64'(bus.o_mem_write_en), 64'd0);
        @(posedge clk);
        #1;
        arst       = 1'b0;
        man_access = 1'b0;
        @(negedge clk);
        chk_eq("rw_gnt_after", 64'({bus.o_gnt1, bus.o_gnt0}), 64'd0);
        chk_eq("rw_beat_after", 64'(bus.o_beat_cnt), 64'd0);
        chk_eq("rw_word2_kept", 64'(mem[12'hC02]), 64'(32'hC0DE_0C02));
        chk_eq("rw_word1_written", 64'(mem[12'hC01]), 64'(32'h201));
        @(posedge clk);
        #1;

        // Random concurrent traffic in disjoint regions.
        man_mode = 1'b0;
        ord_en   = 1'b0;
        wait_cycles(2);
        fork
            for (int k = 0; k < 12; k++) begin
                bit          we;
                logic [63:0] a;
                we = 1'($urandom_range(0, 1));
                a  = 64'h0400 + 64'($urandom_range(0, 16'h7FF));
                run_burst(0, we, a, 32'($urandom), 1);
                wait_cycles($urandom_range(0, 3));
            end
            for (int k = 0; k < 12; k++) begin
                bit          we;
                logic [63:0] a;
                we = 1'($urandom_range(0, 1));
                a  = 64'h2400 + 64'($urandom_range(0, 16'h7FF));
                run_burst(1, we, a, 32'($urandom), 1);
                wait_cycles($urandom_range(0, 3));
            end
        join
        wait_cycles(5);

        chk_eq("drain_beat0", 64'(exp_beat0.size()), 64'd0);
        chk_eq("drain_beat1", 64'(exp_beat1.size()), 64'd0);
        chk_eq("drain_rd0", 64'(exp_rd0.size()), 64'd0);
        chk_eq("drain_rd1", 64'(exp_rd1.size()), 64'd0);
        chk_eq("drain_own", 64'(exp_own.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk_eq("mem_sweep_mismatches", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and burst sequencer in front of the single-port, variable-latency simulated memory.
- Requester 0 is the instruction-fetch side; requester 1 is the data side.
- Each grant runs one burst of BURST_LEN word beats at consecutive word addresses.
- Each beat completes on the memory's one-cycle success pulse.
- The block returns per-beat read data and a completion pulse to the granted requester.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 64, byte address width.
- BURST_LEN, 4, beats per grant; power of two, at least 1.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  synchronous active-high reset.
- i_req0  in  1  requester 0 burst request.
- i_we0  in  1  requester 0 write (1) / read (0).
- i_addr0  in  ADDR_WIDTH  requester 0 start byte address.
- i_wdata0  in  DATA_WIDTH  requester 0 write data for the beat given by o_beat_cnt.
- i_req1, i_we1, i_addr1, i_wdata1: same as above, for requester 1.
- o_gnt0  out  1  requester 0 owns the memory (BUSY or DONE).
- o_gnt1  out  1  requester 1 owns the memory (BUSY or DONE).
- o_beat_cnt  out  log2(BURST_LEN) (min 1)  index of the current beat.
- o_rvalid0  out  1  o_rdata holds a completed beat for requester 0.
- o_rvalid1  out  1  o_rdata holds a completed beat for requester 1.
- o_rdata  out  DATA_WIDTH  registered read data.
- o_done0  out  1  one-cycle pulse: requester 0 burst finished.
- o_done1  out  1  one-cycle pulse: requester 1 burst finished.
- o_mem_write_en  out  1  to memory write enable.
- o_mem_data  out  DATA_WIDTH  to memory write data.
- o_mem_addr  out  ADDR_WIDTH  to memory byte address.
- i_mem_read_data  in  DATA_WIDTH  from memory, combinational read data.
- i_mem_access  in  1  from memory, one-cycle beat-complete pulse.

Behaviour:
- Clock and reset: one clock, i_clk. i_arst is synchronous and active-high.
- Reset values:
  - state IDLE, beat counter 0, last-served pointer = 1 (so requester 0 wins the first tie).
  - latched address 0.
  - all o_gnt*, o_rvalid*, o_done* = 0; o_rdata = 0.
  - o_mem_write_en is combinationally forced to 0 while i_arst is high.
- States:
  - IDLE -> BUSY when any request is high. The grant is registered, so o_gnt* rises the cycle after the request is sampled.
  - BUSY -> DONE on i_mem_access when the beat counter equals BURST_LEN-1.
  - DONE -> IDLE unconditionally after one cycle.
- Arbitration (IDLE only):
  - One request high: grant it.
  - Both high: grant the requester that is not the last-served one.
  - The last-served pointer updates at grant.
- Grant latch: on grant, latch the owner, its we, and its address with bits [1:0] cleared.
- Addressing:
  - o_mem_addr = latched address + 4*beat counter.
  - Linear increment, no wrap; carry out of ADDR_WIDTH is discarded.
  - o_mem_addr holds its last value in IDLE and DONE.
- Beat handshake in BUSY:
  - When i_mem_access = 1, the beat completes and the beat counter increments (it wraps to 0 on the last beat).
  - i_mem_access pulses in IDLE or DONE are ignored.
- Reads:
  - On a beat completion, o_rdata <= i_mem_read_data and the owner's o_rvalid pulses for one cycle (the next cycle).
  - Latency from i_mem_access to o_rvalid is 1 cycle.
- Writes:
  - o_mem_data = owner's i_wdata, combinational.
  - o_mem_write_en = BUSY & we & i_mem_access & ~i_arst. Exactly one write-enable cycle per beat; no spurious writes.
  - The owner indexes its write data with o_beat_cnt.
  - For writes, o_rvalid stays 0.
- Completion:
  - The owner's o_done is high during DONE. For reads it coincides with the final o_rvalid.
  - o_gnt stays high through DONE and drops on entering IDLE.
- Requester obligations:
  - Hold i_req, i_we and i_addr from assertion until o_done.
  - Deassert i_req by the cycle after o_done, otherwise a new burst is granted.
  - Requester-side changes during BUSY are ignored, except the i_wdata of the owner.
  - Dropping i_req mid-burst does not abort the burst.
- Non-owner: the non-owner's request is held pending; it is never lost.
- Reset mid-burst: abort immediately, no write on the reset cycle, return to the reset state. Requesters must reissue the burst.
- BURST_LEN = 1: BUSY -> DONE on the first access pulse; o_beat_cnt is tied to 0.

Test Plan:
- Single read: i_req0=1, i_we0=0, i_addr0=0x1003, memory holds 0xA,0xB,0xC,0xD at words 0x1000..0x100C.
  - -> o_mem_addr 0x1000, 0x1004, 0x1008, 0x100C in turn.
  - -> o_rvalid0 four times with o_rdata 0xA..0xD.
  - -> o_done0 with the last beat; o_gnt1 never rises.
- Write burst: i_req1=1, i_we1=1, addr 0x2000, i_wdata1 = 0x100+o_beat_cnt.
  - -> exactly 4 o_mem_write_en cycles, each coinciding with i_mem_access.
  - -> memory holds 0x100..0x103 at 0x2000..0x200C; o_rvalid1 stays 0.
- Tie arbitration: both requests asserted together out of reset, each held until its own o_done, then dropped.
  - -> requester 0 served first, requester 1 next.
  - -> then assert both again: requester 0 granted next (pointer = 1 after requester 1's burst).
- Back-to-back repeat: requester 0 keeps i_req0 high across o_done with requester 1 also requesting.
  - -> requester 1 granted after the DONE/IDLE cycles.
  - -> requester 0's next burst follows, with no starvation.
- Ignored access: i_mem_access pulses while IDLE.
  - -> no state change, no o_rvalid, o_mem_write_en=0.
- Reset mid-write: assert i_arst during beat 2 of a write, coincident with i_mem_access.
  - -> o_mem_write_en=0 that cycle; next cycle IDLE, o_gnt*=0, o_beat_cnt=0.
  - -> word at beat 2 unchanged.
